// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and the
// halt word the processor bench uses as its program-completion marker.
package imem_loader_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_TERM  = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd4;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_loader.sv
// Streams program words into instruction memory, appends a halt word and holds
// the processor in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              error_q, error_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              accept;

  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign accept   = in_valid && in_ready;

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    error_d      = error_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = 1'b1;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          addr_d       = '0;
          word_count_d = '0;
          error_d      = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = in_data;
          word_count_d = word_count_q + (ADDR_W+1)'(1);
          // Last slot: stop without incrementing so addr never wraps.
          if (addr_q == LAST_ADDR) begin
            if (in_last) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DRAIN;
              error_d = 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (in_last) begin
              state_d = ST_TERM;
            end
          end
        end
      end
      ST_TERM: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = addr_q;
        imem_wdata_d = DATA_W'(HALT_WORD);
        state_d      = ST_RUN;
      end
      ST_DRAIN: begin
        if (accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cpu_reset_d = start;
        done_d      = !start;
        if (start) begin
          state_d      = ST_LOAD;
          addr_d       = '0;
          word_count_d = '0;
          error_d      = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      error_q      <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      error_q      <= error_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
